// File: rtl/sll_multicycle_if.sv
// rtl/sll_multicycle_if.sv - request/result bundle between the core and the iterative left shifter
interface sll_multicycle_if #(
    parameter int WIDTH      = 32,
    parameter int SHAMT_BITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      data_operand;
    logic [SHAMT_BITS-1:0] shamt;
    logic [WIDTH-1:0]      result;
    logic                  bits_lost;
    logic                  busy;
    logic                  data_resultRDY;

    modport master (
        output start, data_operand, shamt,
        input  result, bits_lost, busy, data_resultRDY
    );

    modport slave (
        input  start, data_operand, shamt,
        output result, bits_lost, busy, data_resultRDY
    );
endinterface

// File: rtl/sll_multicycle.sv
// rtl/sll_multicycle.sv - iterative logical left shifter, one power-of-two stage per clock
module sll_multicycle #(
    parameter int WIDTH      = 32,
    parameter int SHAMT_BITS = 5
) (
    input  logic              clock,
    input  logic              reset,
    sll_multicycle_if.slave   bus
);
    localparam int STAGE_BITS = (SHAMT_BITS > 1) ? $clog2(SHAMT_BITS) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state, state_next;
    logic [WIDTH-1:0]      work;
    logic [SHAMT_BITS-1:0] shamt_q;
    logic [STAGE_BITS-1:0] stage;
    logic                  lost;

    logic                  accept;
    logic [SHAMT_BITS-1:0] step;
    logic [WIDTH-1:0]      shifted;
    logic [WIDTH-1:0]      keep_mask;
    logic                  spill;

    assign accept    = bus.start && (state != SHIFT);
    assign step      = SHAMT_BITS'(1) << stage;
    assign shifted   = work << step;
    // Bits that survive the shift; anything set outside this mask falls off the top.
    assign keep_mask = {WIDTH{1'b1}} >> step;
    assign spill     = |(work & ~keep_mask);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (stage == '0) state_next = DONE;
            DONE:    state_next = bus.start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            work    <= '0;
            shamt_q <= '0;
            stage   <= '0;
            lost    <= 1'b0;
        end else if (accept) begin
            work    <= bus.data_operand;
            shamt_q <= bus.shamt;
            stage   <= STAGE_BITS'(SHAMT_BITS - 1);
            lost    <= 1'b0;
        end else if (state == SHIFT) begin
            if (shamt_q[stage]) begin
                work <= shifted;
                lost <= lost | spill;
            end
            if (stage != '0) begin
                stage <= stage - 1'b1;
            end
        end
    end

    assign bus.result         = work;
    assign bus.bits_lost      = lost;
    assign bus.busy           = (state == SHIFT);
    assign bus.data_resultRDY = (state == DONE);
endmodule
